pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the execute stage of the 2-wide core. It supersedes the fixed-width, fixed-amount shift cells.
- Supports logical left, logical right, arithmetic right and rotate right by a variable amount.
- Runs with a valid/ready handshake and a pipeline flush for mispredicts.
- Carries a destination tag so results can be written back out of the ALU's single-cycle path.

---
 rtl/pipelined_shifter.sv | 136 +++++++++++++
 tb/tb_pipelined_shifter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// Elastic, pipelined barrel shifter (SLL/SRL/SRA/ROR) with tag pass-through and flush.
// Shift level i is evaluated in register stage floor(i*PIPE/SHW).
module pipelined_shifter #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned PIPE  = 2,
    parameter  int unsigned TAG_W = 5,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    logic [WIDTH-1:0] r_data  [PIPE];
    logic [SHW-1:0]   r_shamt [PIPE];
    logic [1:0]       r_mode  [PIPE];
    logic [TAG_W-1:0] r_tag   [PIPE];
    logic             r_sign  [PIPE];
    logic [PIPE-1:0]  r_valid;

    logic [WIDTH-1:0] w_din   [PIPE];
    logic [WIDTH-1:0] w_dout  [PIPE];
    logic [SHW-1:0]   w_sh_in [PIPE];
    logic [1:0]       w_md_in [PIPE];
    logic [TAG_W-1:0] w_tg_in [PIPE];
    logic             w_sg_in [PIPE];
    logic [PIPE-1:0]  w_adv;
    logic [PIPE-1:0]  w_load;

    // Apply only the shift levels owned by stage stg; SRA fills with the carried sign.
    function automatic logic [WIDTH-1:0] shift_levels(
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   sh,
        input logic [1:0]       mode,
        input logic             sign,
        input int unsigned      stg
    );
        logic [WIDTH-1:0] v;
        int unsigned      amt;
        v = d;
        for (int unsigned i = 0; i < SHW; i++) begin
            amt = 32'(1) << i;
            if ((((i * PIPE) / SHW) == stg) && sh[i]) begin
                case (mode)
                    MODE_SLL: v = v << amt;
                    MODE_SRL: v = v >> amt;
                    MODE_SRA: v = (v >> amt) | (sign ? ~({WIDTH{1'b1}} >> amt) : '0);
                    default:  v = (v >> amt) | (v << (WIDTH - amt));
                endcase
            end
        end
        return v;
    endfunction

    // Advance chain resolves from the output back towards the input.
    always_comb begin
        w_adv = '0;
        w_adv[PIPE-1] = r_valid[PIPE-1] & out_ready;
        for (int k = int'(PIPE) - 2; k >= 0; k--) begin
            w_adv[k] = r_valid[k] & (~r_valid[k+1] | w_adv[k+1]);
        end
    end

    assign in_ready = ~r_valid[0] | w_adv[0];

    for (genvar g = 0; g < PIPE; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign w_din[g]   = in_data;
            assign w_sh_in[g] = in_shamt;
            assign w_md_in[g] = in_mode;
            assign w_tg_in[g] = in_tag;
            assign w_sg_in[g] = in_data[WIDTH-1];
            assign w_load[g]  = in_valid & in_ready;
        end else begin : g_next
            assign w_din[g]   = r_data[g-1];
            assign w_sh_in[g] = r_shamt[g-1];
            assign w_md_in[g] = r_mode[g-1];
            assign w_tg_in[g] = r_tag[g-1];
            assign w_sg_in[g] = r_sign[g-1];
            assign w_load[g]  = w_adv[g-1];
        end
        assign w_dout[g] = shift_levels(w_din[g], w_sh_in[g], w_md_in[g], w_sg_in[g], g);
    end

    // Reset beats flush, flush beats advance; payload only moves on load so stalls hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < PIPE; k++) begin
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_mode[k]  <= '0;
                r_tag[k]   <= '0;
                r_sign[k]  <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < PIPE; k++) begin
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                end else if (w_adv[k]) begin
                    r_valid[k] <= 1'b0;
                end
                if (w_load[k]) begin
                    r_data[k]  <= w_dout[k];
                    r_shamt[k] <= w_sh_in[k];
                    r_mode[k]  <= w_md_in[k];
                    r_tag[k]   <= w_tg_in[k];
                    r_sign[k]  <= w_sg_in[k];
                end
            end
        end
    end

    assign out_valid = r_valid[PIPE-1];
    assign out_data  = r_data[PIPE-1];
    assign out_tag   = r_tag[PIPE-1];
    assign out_zero  = r_valid[PIPE-1] & (r_data[PIPE-1] == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (WIDTH=32, PIPE=2, TAG_W=5) plus a full mode/amount sweep.
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [1:0]  in_mode;

    int checks = 0;
    int errors = 0;

    pipelined_shifter #(.WIDTH(32), .PIPE(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s, input logic [4:0] t);
        in_valid = 1'b1; in_mode = m; in_data = d; in_shamt = s; in_tag = t;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input logic [1:0] m);
        logic [63:0] dd;
        case (m)
            2'd0: return d << n;
            2'd1: return d >> n;
            2'd2: return 32'($signed(d) >>> n);
            default: begin
                dd = {d, d} >> n;
                return dd[31:0];
            end
        endcase
    endfunction

    logic [31:0] exp_q[$];
    logic [4:0]  tag_q[$];
    logic [31:0] e;
    int acc, got, cyc, sent;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Mode coverage, back-to-back with out_ready high
        put(2'b10, 32'h8000_0000, 5'd8, 5'd3);  tick();
        chk("m_lat_empty", 32'(out_valid), 32'd0);
        put(2'b01, 32'h8000_0000, 5'd31, 5'd4); tick();
        chk("m_sra_valid", 32'(out_valid), 32'd1);
        chk("m_sra_data", out_data, 32'hFF80_0000);
        chk("m_sra_tag", 32'(out_tag), 32'd3);
        put(2'b00, 32'h0000_0001, 5'd31, 5'd5); tick();
        chk("m_srl_data", out_data, 32'h0000_0001);
        chk("m_srl_tag", 32'(out_tag), 32'd4);
        put(2'b11, 32'h0000_000F, 5'd4, 5'd6);  tick();
        chk("m_sll_data", out_data, 32'h8000_0000);
        in_valid = 1'b0; tick();
        chk("m_ror_data", out_data, 32'hF000_0000);
        chk("m_ror_tag", 32'(out_tag), 32'd6);
        tick();
        chk("m_drained", 32'(out_valid), 32'd0);

        // Zero result and identity shift
        put(2'b01, 32'h0000_0001, 5'd1, 5'd7); tick();
        put(2'b10, 32'h7FFF_FFFF, 5'd0, 5'd8); tick();
        chk("z_valid", 32'(out_valid), 32'd1);
        chk("z_data", out_data, 32'd0);
        chk("z_zero", 32'(out_zero), 32'd1);
        in_valid = 1'b0; tick();
        chk("id_data", out_data, 32'h7FFF_FFFF);
        chk("id_zero", 32'(out_zero), 32'd0);
        tick();

        // Backpressure: out_ready low for 4 cycles while streaming SLL 1 by 0..4
        sent = 0; got = 0; acc = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            out_ready = (c >= 4);
            if (sent < 5) put(2'b00, 32'd1, 5'(sent), 5'(sent)); else in_valid = 1'b0;
            #1;
            if (c == 1) chk("bp_ready_half", 32'(in_ready), 32'd1);
            if (c == 2) chk("bp_ready_full", 32'(in_ready), 32'd0);
            if (c == 4) chk("bp_drain_fill", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, 32'd1 << got);
                got++;
            end
            if (in_valid && in_ready) begin
                sent++;
                if (c < 4) acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bp_acc_stalled", 32'(acc), 32'd2);
        chk("bp_outputs", 32'(got), 32'd5);
        tick();
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Flush with two in flight and a third presented
        out_ready = 1'b0;
        put(2'b00, 32'd1, 5'd1, 5'd1); tick();
        put(2'b00, 32'd1, 5'd2, 5'd2); tick();
        put(2'b00, 32'd1, 5'd3, 5'd3); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid0", 32'(out_valid), 32'd0); tick();
        chk("fl_valid1", 32'(out_valid), 32'd0); tick();
        chk("fl_valid2", 32'(out_valid), 32'd0);
        put(2'b10, 32'hF000_0000, 5'd4, 5'd9); tick();
        in_valid = 1'b0; tick();
        chk("fl_after_valid", 32'(out_valid), 32'd1);
        chk("fl_after_data", out_data, 32'hFF00_0000);
        tick();

        // Flush on empty pipe: in_ready stays high but the input is dropped
        put(2'b00, 32'd5, 5'd0, 5'd1); flush = 1'b1; #1;
        chk("fl_ready_ungated", 32'(in_ready), 32'd1);
        tick(); flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl_discard", 32'(out_valid), 32'd0);

        // Flush during stall with out_ready high: head still transfers
        out_ready = 1'b0;
        put(2'b00, 32'd3, 5'd0, 5'd10); tick();
        put(2'b00, 32'd3, 5'd1, 5'd11); tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; #1;
        chk("fs_head_valid", 32'(out_valid), 32'd1);
        chk("fs_head_data", out_data, 32'd3);
        tick(); flush = 1'b0;
        chk("fs_squashed", 32'(out_valid), 32'd0);
        tick();
        chk("fs_squashed2", 32'(out_valid), 32'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        put(2'b00, 32'd7, 5'd1, 5'd12); tick();
        put(2'b00, 32'd7, 5'd2, 5'd13); tick();
        in_valid = 1'b0; rst_n = 1'b0; tick();
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_data", out_data, 32'd0);
        chk("rm_tag", 32'(out_tag), 32'd0);
        chk("rm_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rm_no_stale", 32'(out_valid), 32'd0);
        end

        // Sweep every mode x amount with random gaps and stalls
        sent = 0; got = 0; cyc = 0;
        while (got < 128 && cyc < 4000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 128 && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_mode  = 2'(sent / 32);
                in_shamt = 5'(sent % 32);
                in_data  = (sent % 5 == 0) ? 32'h8000_0001 : $urandom;
                in_tag   = 5'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("sw_data", out_data, e);
                chk("sw_tag", 32'(out_tag), 32'(tag_q.pop_front()));
                chk("sw_zero", 32'(out_zero), 32'(e == 32'd0));
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_mode));
                tag_q.push_back(in_tag);
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("sw_completed", 32'(got), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
